// File: rtl/fir_filter_param.sv
// Pipelined direct-form FIR filter: run-time loadable coefficients, valid-qualified
// samples, round-half-up scaling and saturating output. Latency 3 clocks, 1 sample/clock.
module fir_filter_param #(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned COEF_W = 8,
  parameter int unsigned TAPS   = 8,
  parameter int unsigned SHIFT  = 0,
  parameter int unsigned OUT_W  = 17
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     in_valid_i,
  input  logic [DATA_W-1:0]        in_data_i,
  input  logic                     coef_we_i,
  input  logic [$clog2(TAPS)-1:0]  coef_addr_i,
  input  logic [COEF_W-1:0]        coef_data_i,
  output logic                     out_valid_o,
  output logic [OUT_W-1:0]         out_data_o,
  output logic                     sat_flag_o
);

  localparam int unsigned ADDR_W  = $clog2(TAPS);
  localparam int unsigned PROD_W  = DATA_W + COEF_W;
  localparam int unsigned ACC_W   = PROD_W + ADDR_W;
  // One guard bit for the rounding add, and wide enough to hold the output range.
  localparam int unsigned EXT_W   = ((ACC_W + 1 > OUT_W) ? ACC_W + 1 : OUT_W) + 1;
  localparam int unsigned BIAS_SH = (SHIFT > 0) ? SHIFT - 1 : 0;

  localparam logic signed [EXT_W-1:0] SAT_MAX = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SAT_MIN = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic signed [EXT_W-1:0] ROUND_C = (SHIFT > 0) ? (EXT_W'(1) << BIAS_SH) : '0;

  logic signed [DATA_W-1:0] x_q [TAPS];
  logic signed [DATA_W-1:0] x_d [TAPS];
  logic signed [COEF_W-1:0] h_q [TAPS];
  logic signed [COEF_W-1:0] h_d [TAPS];
  logic signed [PROD_W-1:0] p_q [TAPS];
  logic signed [PROD_W-1:0] p_d [TAPS];
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [EXT_W-1:0]  r_c;
  logic                     v0_q, v1_q, v2_q, out_valid_q;
  logic [OUT_W-1:0]         out_data_q, out_data_d;
  logic                     sat_q, sat_d;

  // Delay line shifts only on accepted samples; coefficient bank write port.
  always_comb begin
    x_d = x_q;
    h_d = h_q;
    if (in_valid_i) begin
      x_d[0] = in_data_i;
      for (int k = 1; k < TAPS; k++) begin
        x_d[k] = x_q[k-1];
      end
    end
    if (coef_we_i && (32'(coef_addr_i) < TAPS)) begin
      h_d[coef_addr_i] = coef_data_i;
    end
  end

  // Multiply and accumulate stages.
  always_comb begin
    acc_d = '0;
    for (int k = 0; k < TAPS; k++) begin
      p_d[k] = PROD_W'(x_q[k]) * PROD_W'(h_q[k]);
      acc_d  = acc_d + ACC_W'(p_q[k]);
    end
  end

  // Round, shift and clip; out_data only moves on a valid result.
  always_comb begin
    r_c        = (EXT_W'(acc_q) + ROUND_C) >>> SHIFT;
    out_data_d = out_data_q;
    sat_d      = 1'b0;
    if (v2_q) begin
      if (r_c > SAT_MAX) begin
        out_data_d = {1'b0, {(OUT_W-1){1'b1}}};
        sat_d      = 1'b1;
      end else if (r_c < SAT_MIN) begin
        out_data_d = {1'b1, {(OUT_W-1){1'b0}}};
        sat_d      = 1'b1;
      end else begin
        out_data_d = r_c[OUT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int k = 0; k < TAPS; k++) begin
        x_q[k] <= '0;
        h_q[k] <= '0;
        p_q[k] <= '0;
      end
      acc_q       <= '0;
      v0_q        <= 1'b0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sat_q       <= 1'b0;
    end else begin
      x_q         <= x_d;
      h_q         <= h_d;
      p_q         <= p_d;
      acc_q       <= acc_d;
      v0_q        <= in_valid_i;
      v1_q        <= v0_q;
      v2_q        <= v1_q;
      out_valid_q <= v2_q;
      out_data_q  <= out_data_d;
      sat_q       <= sat_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign sat_flag_o  = sat_q;

endmodule

// File: tb/tb_fir_filter_param.sv
// Scoreboard bench for fir_filter_param: three instances (default, OUT_W=12, SHIFT=4)
// share one stimulus stream and are checked against a convolution model.
module tb_fir_filter_param;

  localparam int DW = 10;
  localparam int CW = 8;
  localparam int T  = 8;
  localparam int AW = 3;
  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n     = 1'b0;
  logic          in_valid  = 1'b1;
  logic [DW-1:0] in_data   = DW'(300);
  logic          coef_we   = 1'b0;
  logic [AW-1:0] coef_addr = '0;
  logic [CW-1:0] coef_data = '0;

  logic        ov0, ov1, ov2, sf0, sf1, sf2;
  logic [16:0] od0;
  logic [11:0] od1;
  logic [16:0] od2;

  fir_filter_param u0 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_data_i(in_data),
    .coef_we_i(coef_we), .coef_addr_i(coef_addr), .coef_data_i(coef_data),
    .out_valid_o(ov0), .out_data_o(od0), .sat_flag_o(sf0));

  fir_filter_param #(.OUT_W(12)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_data_i(in_data),
    .coef_we_i(coef_we), .coef_addr_i(coef_addr), .coef_data_i(coef_data),
    .out_valid_o(ov1), .out_data_o(od1), .sat_flag_o(sf1));

  fir_filter_param #(.SHIFT(4)) u2 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_data_i(in_data),
    .coef_we_i(coef_we), .coef_addr_i(coef_addr), .coef_data_i(coef_data),
    .out_valid_o(ov2), .out_data_o(od2), .sat_flag_o(sf2));

  typedef struct {
    longint data;
    bit     sat;
    int     due;
  } exp_t;

  int     shift_p [NI] = '{0, 0, 4};
  int     outw_p  [NI] = '{17, 12, 17};
  exp_t   q [NI][$];
  longint last [NI];
  int     hm [T];
  int     xm [T];
  int     n_cmp = 0;
  int     n_bad = 0;
  int     cyc   = 0;
  logic   rst_prev = 1'b0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_prev <= rst_n;
  end

  task automatic check(input string name, input int i, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s u%0d cyc=%0d actual=%0d required=%0d", name, i, cyc, act, req);
    end
  endtask

  // Reference: y = sum x[n-k]*h[k] with the coefficients in force at acceptance,
  // then round half up, arithmetic shift and clip to the output range.
  task automatic push_expected();
    longint acc;
    longint r;
    longint mx;
    longint mn;
    exp_t   e;
    acc = 0;
    for (int k = 0; k < T; k++) acc += longint'(xm[k]) * longint'(hm[k]);
    for (int i = 0; i < NI; i++) begin
      if (shift_p[i] > 0) r = (acc + (longint'(1) <<< (shift_p[i] - 1))) >>> shift_p[i];
      else                r = acc;
      mx     = (longint'(1) <<< (outw_p[i] - 1)) - 1;
      mn     = -mx - 1;
      e.sat  = (r > mx) || (r < mn);
      e.data = (r > mx) ? mx : ((r < mn) ? mn : r);
      e.due  = cyc + 4;
      q[i].push_back(e);
    end
  endtask

  // Drives inputs for the next rising edge and advances the model for that edge.
  task automatic step(input bit v, input int d, input bit we, input int a, input int cd, input bit rst);
    @(posedge clk);
    #1;
    rst_n     = !rst;
    in_valid  = v;
    in_data   = DW'(d);
    coef_we   = we;
    coef_addr = AW'(a);
    coef_data = CW'(cd);
    if (rst) begin
      for (int k = 0; k < T; k++) begin
        hm[k] = 0;
        xm[k] = 0;
      end
      for (int i = 0; i < NI; i++) begin
        while (q[i].size() > 0 && q[i][$].due >= cyc + 1) void'(q[i].pop_back());
      end
    end else begin
      if (we && a < T) hm[a] = cd;
      if (v) begin
        for (int k = T - 1; k > 0; k--) xm[k] = xm[k-1];
        xm[0] = d;
        push_expected();
      end
    end
  endtask

  task automatic send(input int d);
    step(1'b1, d, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) step(1'b0, 0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic wr(input int a, input int cd);
    step(1'b0, 0, 1'b1, a, cd, 1'b0);
  endtask

  // Monitor: pops the scoreboard on each out_valid and checks hold/idle behaviour otherwise.
  always @(negedge clk) begin
    bit     v;
    bit     s;
    longint d;
    exp_t   e;
    for (int i = 0; i < NI; i++) begin
      case (i)
        0:       begin v = ov0; s = sf0; d = longint'($signed(od0)); end
        1:       begin v = ov1; s = sf1; d = longint'($signed(od1)); end
        default: begin v = ov2; s = sf2; d = longint'($signed(od2)); end
      endcase
      if (!rst_prev) begin
        check("rst_valid", i, longint'(v), 0);
        check("rst_data", i, d, 0);
        check("rst_sat", i, longint'(s), 0);
        last[i] = 0;
      end else if (v) begin
        if (q[i].size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_valid u%0d cyc=%0d actual=valid required=idle", i, cyc);
        end else begin
          e = q[i].pop_front();
          check("data", i, d, e.data);
          check("sat", i, longint'(s), longint'(e.sat));
          check("latency", i, longint'(cyc), longint'(e.due));
        end
        last[i] = d;
      end else begin
        check("hold", i, d, last[i]);
        check("sat_idle", i, longint'(s), 0);
      end
    end
  end

  initial begin
    // Reset held with a live sample on the input; then zero coefficients give zero output.
    step(1'b1, 300, 1'b0, 0, 0, 1'b1);
    step(1'b1, 300, 1'b0, 0, 0, 1'b1);
    for (int j = 0; j < 6; j++) send(int'($urandom_range(0, 1023)) - 512);
    idle(4);

    // Impulse response with h = 1..8.
    for (int k = 0; k < T; k++) wr(k, k + 1);
    send(100);
    for (int j = 0; j < 8; j++) send(0);
    idle(4);

    // Same impulse with two-cycle bubbles.
    send(100);
    for (int j = 0; j < 8; j++) begin
      idle(2);
      send(0);
    end
    idle(4);

    // Saturation both ways, then a small in-range value.
    for (int k = 0; k < T; k++) wr(k, 127);
    for (int j = 0; j < 12; j++) send(511);
    for (int j = 0; j < 12; j++) send(-512);
    for (int j = 0; j < 12; j++) send(1);
    idle(4);

    // Rounding around the half point.
    wr(0, 1);
    for (int k = 1; k < T; k++) wr(k, 0);
    for (int j = 0; j < 8; j++) send(0);
    send(8); send(7); send(24); send(-8); send(-9);
    idle(4);

    // Coefficient change coinciding with a sample, then reset with samples in flight.
    send(5);
    step(1'b1, 10, 1'b1, 0, 3, 1'b0);
    idle(4);
    send(20);
    send(21);
    step(1'b0, 0, 1'b0, 0, 0, 1'b1);
    send(100);
    for (int j = 0; j < 8; j++) send(0);
    idle(4);

    // Randomised traffic with interleaved coefficient writes and occasional resets.
    for (int j = 0; j < 600; j++) begin
      step($urandom_range(0, 3) != 0,
           int'($urandom_range(0, 1023)) - 512,
           $urandom_range(0, 3) == 0,
           int'($urandom_range(0, T - 1)),
           int'($urandom_range(0, 255)) - 128,
           $urandom_range(0, 149) == 0);
    end
    idle(8);

    for (int i = 0; i < NI; i++) check("drained", i, longint'(q[i].size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
